lead_count_iter: RTL
====================

Name: lead_count_iter

Overview:
- Iterative, parametrised leading-zero/leading-one counter for the MIPS CLZ/CLO datapath.
- Scans the operand one CHUNK_W-bit slice per cycle, from the MSB downwards, and stops early at the first slice that is not uniform.
- Uses a valid/ready handshake on both sides, so it can sit beside the ALU as a multi-cycle functional unit.
- Trades latency for area against a flat priority encoder.

Parameters:
- DATA_W, 32, operand width; must be a multiple of CHUNK_W.
- CHUNK_W, 8, bits examined per SCAN cycle; 1 <= CHUNK_W <= DATA_W.
- CNT_W, $clog2(DATA_W+1), result width (derived; not overridden).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- in_valid  in  1  operand offered
- in_ready  out  1  unit can accept an operand
- cnt_en  in  1  1 = count leading ones, 0 = count leading zeros; sampled at acceptance
- val_i  in  DATA_W  operand
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes the result
- val_o  out  CNT_W  count, in the range 0..DATA_W
- busy  out  1  high in SCAN or DONE

Behaviour:
- NCHUNK = DATA_W/CHUNK_W. Elaboration fails if DATA_W % CHUNK_W != 0.
- Reset (rst==0 at a clock edge):
  - state=IDLE; in_ready=1; out_valid=0; val_o=0; busy=0.
  - Internal acc and idx are cleared.
- Reset mid-SCAN or in DONE:
  - Operand and partial count are discarded.
  - No result is ever presented for the discarded operand.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch val_i and cnt_en; acc=0; idx=0; go to SCAN.
- SCAN:
  - in_ready=0.
  - Each cycle examines chunk idx, where idx 0 is the most-significant slice.
  - Chunk count c = number of leading bits equal to the target bit (target = cnt_en), range 0..CHUNK_W.
  - If c<CHUNK_W or idx==NCHUNK-1: val_o <= acc+c; out_valid <= 1; go to DONE.
  - Else: acc <= acc+CHUNK_W; idx <= idx+1.
- Latency:
  - out_valid rises k cycles after the acceptance edge, where k = number of chunks scanned, 1 <= k <= NCHUNK.
  - All-target operand (e.g. CLZ of 0): k=NCHUNK, result=DATA_W.
- DONE:
  - out_valid=1; val_o held stable while out_ready=0.
  - On out_ready: out_valid <= 0; go to IDLE.
  - in_ready stays 0 in DONE, so there is no same-cycle accept-and-drain; the next accept is possible one cycle later.
- in_valid and in_ready are ignored outside IDLE. Operand changes during SCAN have no effect.
- val_o outside DONE holds the last result. It is 0 after reset.
- Arithmetic: acc is CNT_W bits and cannot overflow, since its maximum is DATA_W.

Optional Feature:
- Macro: LEAD_COUNT_TRAILING_EN.
- With the macro defined:
  - Extra input port mode_trail (1 bit), sampled at acceptance.
  - mode_trail=1 counts trailing zeros/ones instead.
  - Chunks are scanned from the least-significant slice; each slice is bit-reversed before the chunk counter.
  - Termination and latency rules are otherwise identical.
- Without the macro: the port is absent and only leading counts exist.

Decomposition:
- Package lead_cnt_pkg holds:
  - state enum lc_state_e {LC_IDLE, LC_SCAN, LC_DONE}.
  - Localparam function for CNT_W.
  - Chunk-select helper function.
- Sub-module lead_chunk_cnt (parameter CHUNK_W):
  - Combinational; inputs chunk and target bit; output count 0..CHUNK_W.
  - Written as a generic loop priority scan, not a casez table.
  - Instantiated once in the top block.

Test Plan:
- Sparse-operand CLZ:
  - Stimulus: DATA_W=32, CHUNK_W=8; val_i=32'h0001_0000, cnt_en=0.
  - Required: val_o=15; out_valid 2 cycles after accept.
- All-zero and all-one operands:
  - CLZ of 32'h0000_0000 -> val_o=32 at k=4.
  - CLO of 32'hFFFF_FFFF -> val_o=32 at k=4.
- Mid-length and zero-length CLO:
  - CLO of 32'hFFFF_FFF0 -> val_o=28, k=4.
  - CLO of 32'h7FFF_FFFF -> val_o=0, k=1.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles after out_valid, and drive in_valid=1 throughout.
  - Required: val_o stable, in_ready=0, no second accept; the accept occurs one cycle after out_ready is asserted.
- Reset mid-operation:
  - Stimulus: drive rst=0 during the second SCAN cycle.
  - Required: next cycle out_valid=0, in_ready=1, busy=0; no stale result appears later.
- Trailing count (LEAD_COUNT_TRAILING_EN defined):
  - Stimulus: mode_trail=1, cnt_en=0, val_i=32'h0000_0100.
  - Required: val_o=8, k=2.
- Parameter sweep:
  - Configurations: CHUNK_W=1, DATA_W=8 and CHUNK_W=32, DATA_W=32.
  - Required: random operands match a reference-model count.

Source files
------------

// File: rtl/lead_count_iter_pkg.sv
// Shared types and helpers for the iterative leading/trailing count unit.
// Optional trailing-count mode in the top is enabled by LEAD_COUNT_TRAILING_EN.
package lead_cnt_pkg;

  typedef enum logic [1:0] {LC_IDLE, LC_SCAN, LC_DONE} lc_state_e;

  // Widest operand the chunk-select helper can handle.
  localparam int LC_MAX_W = 256;

  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

  // Bring slice number 'slot' (0 = least significant) down to bit 0.
  function automatic logic [LC_MAX_W-1:0] chunk_sel(input logic [LC_MAX_W-1:0] val,
                                                    input int chunk_w,
                                                    input int slot);
    return val >> (slot * chunk_w);
  endfunction

endpackage

// File: rtl/lead_count_iter_chunk.sv
// Combinational count of leading bits equal to i_target within one chunk.
module lead_chunk_cnt
  import lead_cnt_pkg::*;
#(
  parameter  int CHUNK_W = 8,
  localparam int CCW     = cnt_width(CHUNK_W)
) (
  input  logic [CHUNK_W-1:0] i_chunk,
  input  logic               i_target,
  output logic [CCW-1:0]     o_count
);

  logic w_hit;

  always_comb begin
    o_count = '0;
    w_hit   = 1'b0;
    for (int i = CHUNK_W - 1; i >= 0; i--) begin
      if (!w_hit) begin
        if (i_chunk[i] == i_target) o_count = o_count + CCW'(1);
        else                        w_hit   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lead_count_iter.sv
// Iterative CLZ/CLO unit: one CHUNK_W slice per cycle, early exit on a mixed slice.
// Define LEAD_COUNT_TRAILING_EN to add the mode_trail port (trailing counts).
//
//   state   | meaning
//   LC_IDLE | ready for an operand
//   LC_SCAN | examining one chunk per cycle
//   LC_DONE | result presented until out_ready
module lead_count_iter
  import lead_cnt_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int CHUNK_W = 8,
  parameter int CNT_W   = cnt_width(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              cnt_en,
  input  logic [DATA_W-1:0] val_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  val_o,
  output logic              busy
`ifdef LEAD_COUNT_TRAILING_EN
  ,
  input  logic              mode_trail
`endif
);

  localparam int NCHUNK = DATA_W / CHUNK_W;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int CCW    = cnt_width(CHUNK_W);

  if (DATA_W % CHUNK_W != 0) begin : g_bad_chunk
    $error("lead_count_iter: DATA_W must be a multiple of CHUNK_W");
  end
  if (DATA_W > LC_MAX_W || CHUNK_W < 1) begin : g_bad_width
    $error("lead_count_iter: unsupported DATA_W/CHUNK_W");
  end

  lc_state_e          r_state, w_next;
  logic [DATA_W-1:0]  r_val;
  logic               r_tgt;
  logic [CNT_W-1:0]   r_acc;
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_res;
  logic               w_accept;
  logic               w_stop;
  int                 w_slot;
  logic [CHUNK_W-1:0] w_slice;
  logic [CHUNK_W-1:0] w_chunk;
  logic [CCW-1:0]     w_c;
`ifdef LEAD_COUNT_TRAILING_EN
  logic               r_trail;
  logic [CHUNK_W-1:0] w_slice_rev;
`endif

  // Leading mode walks slices MSB-first; trailing mode walks LSB-first on reversed slices.
  always_comb begin
    w_slot  = NCHUNK - 1 - int'(r_idx);
`ifdef LEAD_COUNT_TRAILING_EN
    if (r_trail) w_slot = int'(r_idx);
`endif
    w_slice = CHUNK_W'(chunk_sel(LC_MAX_W'(r_val), CHUNK_W, w_slot));
    w_chunk = w_slice;
`ifdef LEAD_COUNT_TRAILING_EN
    for (int i = 0; i < CHUNK_W; i++) w_slice_rev[i] = w_slice[CHUNK_W-1-i];
    if (r_trail) w_chunk = w_slice_rev;
`endif
  end

  lead_chunk_cnt #(.CHUNK_W(CHUNK_W)) u_chunk_cnt (
    .i_chunk  (w_chunk),
    .i_target (r_tgt),
    .o_count  (w_c)
  );

  assign w_accept = in_valid && in_ready;
  assign w_stop   = (w_c != CCW'(CHUNK_W)) || (r_idx == IDX_W'(NCHUNK - 1));

  always_ff @(posedge clk) begin
    if (!rst) r_state <= LC_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      LC_IDLE: if (w_accept) w_next = LC_SCAN;
      LC_SCAN: if (w_stop)   w_next = LC_DONE;
      LC_DONE: if (out_ready) w_next = LC_IDLE;
      default: w_next = LC_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == LC_IDLE);
    out_valid = (r_state == LC_DONE);
    busy      = (r_state != LC_IDLE);
    val_o     = r_res;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_val   <= '0;
      r_tgt   <= 1'b0;
      r_acc   <= '0;
      r_idx   <= '0;
      r_res   <= '0;
`ifdef LEAD_COUNT_TRAILING_EN
      r_trail <= 1'b0;
`endif
    end else begin
      case (r_state)
        LC_IDLE: begin
          if (w_accept) begin
            r_val   <= val_i;
            r_tgt   <= cnt_en;
            r_acc   <= '0;
            r_idx   <= '0;
`ifdef LEAD_COUNT_TRAILING_EN
            r_trail <= mode_trail;
`endif
          end
        end
        LC_SCAN: begin
          if (w_stop) begin
            r_res <= r_acc + CNT_W'(w_c);
          end else begin
            r_acc <= r_acc + CNT_W'(CHUNK_W);
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
